instr_fetch_unit: RTL and testbench

- Fetch stage that consumes the current program counter and drives the next one back into the PC register's `data_in`.
- Issues instruction-memory reads over a valid/ready request channel and accepts responses on a valid-only response channel.
- Buffers returned instructions with their fetch address in a 2-entry queue and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/fetch_queue.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and queue entry layout for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h003F_FFFC;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response channel and decode-side instruction handshake.
interface instr_fetch_unit_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst} pairs; flush beats push, a pop in the flush cycle still completes.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; the head is masked by empty at the top level.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives next PC, issues one imem read at a time, queues results for decode.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_misaligned flag and blocks misaligned fetches.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  output logic [31:0]        pc_next,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic               fetch_misaligned,
`endif
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t     state;
  logic             discard;
  logic [31:0]      req_pc;
  logic             align_ok;
  logic             accept;
  logic             push;
  logic             pop;
  logic             flush;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ_next;
  logic             space_after;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

`ifdef FETCH_ALIGN_CHECK_EN
  assign align_ok = (pc[1:0] == 2'b00);
`else
  assign align_ok = 1'b1;
`endif

  assign bus.imem_req_valid = !reset && (state == REQ) && align_ok;
  assign bus.imem_req_addr  = {pc[31:2], 2'b00};
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.inst_valid = !reset && !empty;
  assign bus.inst_data  = bus.inst_valid ? head.inst : 32'd0;
  assign bus.inst_pc    = bus.inst_valid ? head.pc   : 32'd0;

  assign pop        = bus.inst_valid && bus.inst_ready;
  assign flush      = redirect_valid && !reset;
  assign push       = !reset && (state == WAIT) && bus.imem_rsp_valid && !discard && !redirect_valid;
  assign push_entry = '{pc: req_pc, inst: bus.imem_rsp_data};

  assign occ_next    = {1'b0, count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  assign space_after = (occ_next < (CNT_W+1)'(BUF_DEPTH));

  always_comb begin
    pc_next = pc;
    if (reset)               pc_next = RESET_PC;
    else if (redirect_valid) pc_next = redirect_pc;
    else if (accept)         pc_next = pc + PC_INCR;
  end

  fetch_queue #(.DEPTH(BUF_DEPTH)) u_queue (
    .clk        (clk),
    .rst        (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // Redirect overrides every state; discard marks the one in-flight response as stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      discard <= 1'b0;
    end else if (redirect_valid) begin
      case (state)
        REQ: begin
          if (accept) begin
            state   <= WAIT;
            discard <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: if (!full && align_ok) state <= REQ;
        REQ:  if (accept) state <= WAIT;
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            discard <= 1'b0;
            state   <= space_after ? REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req_pc <= bus.imem_req_addr;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) fetch_misaligned <= 1'b0;
    else if (((state == IDLE) || (state == REQ)) && !align_ok) fetch_misaligned <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC register looped through the DUT, latency-programmable memory model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h003F_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misaligned (fetch_misaligned),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pc <= pc_next;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int cyc;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_data[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] dp(input int i);
    if (i < dlv_pc.size()) return dlv_pc[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dd(input int i);
    if (i < dlv_data.size()) return dlv_data[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rq(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    dlv_pc.delete();
    dlv_data.delete();
  endtask

  // One clock: log handshakes of the ending cycle, then drive the memory response for the new one.
  task automatic tick();
    logic        acc;
    logic        dlv;
    logic [31:0] a;
    #1;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    a   = bus.imem_req_addr;
    dlv = bus.inst_valid && bus.inst_ready;
    if (acc) req_log.push_back(a);
    if (dlv) begin
      dlv_pc.push_back(bus.inst_pc);
      dlv_data.push_back(bus.inst_data);
    end
    @(posedge clk);
    cyc++;
    #1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (acc) begin
        pend_addr.push_back(a);
        pend_due.push_back(cyc + lat - 1);
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_dlv(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && dlv_pc.size() < n; i++) tick();
    check_eq({tag, "_count"}, 32'(dlv_pc.size()), 32'(n));
  endtask

  task automatic wait_acc(input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) found = 1'b1;
      else tick();
    end
    check_eq({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    redirect_valid     = 1'b0;
    redirect_pc        = 32'd0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.inst_ready     = 1'b1;
    lat                = 1;
    cyc                = 0;

    // Reset release and first three sequential fetches
    tick();
    check_eq("rst_pc_next", pc_next, RST_PC);
    check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("rst_inst_data", bus.inst_data, 32'd0);
    check_eq("rst_inst_pc", bus.inst_pc, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    clear_logs();
    wait_dlv(3, 40, "rst_seq");
    check_eq("rst_first_req", rq(0), RST_PC);
    check_eq("rst_dlv0", dp(0), RST_PC);
    check_eq("rst_dlv1", dp(1), 32'h0040_0000);
    check_eq("rst_dlv2", dp(2), 32'h0040_0004);
    check_eq("rst_data0", dd(0), mem_word(RST_PC));

    // Backpressure: queue fills after two fetches, then fetching resumes in order
    bus.inst_ready = 1'b0;
    do_reset(2);
    repeat (20) tick();
    check_eq("bp_req_count", 32'(req_log.size()), 32'd2);
    check_eq("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("bp_pc_next", pc_next, 32'h0040_0004);
    check_eq("bp_head_pc", bus.inst_pc, RST_PC);
    check_eq("bp_head_data", bus.inst_data, mem_word(RST_PC));
    tick();
    check_eq("bp_pc_hold", pc_next, 32'h0040_0004);
    bus.inst_ready = 1'b1;
    wait_dlv(6, 60, "bp_resume");
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("bp_dlv%0d", i), dp(i), RST_PC + 32'(4 * i));
      check_eq($sformatf("bp_req%0d", i), rq(i), RST_PC + 32'(4 * i));
    end

    // Redirect while a response is still outstanding
    lat = 3;
    bus.inst_ready = 1'b1;
    do_reset(2);
    wait_acc(20, "ro_acc");
    tick();
    do_redirect(32'h0040_0100);
    clear_logs();
    wait_dlv(2, 40, "ro_after");
    check_eq("ro_req0", rq(0), 32'h0040_0100);
    check_eq("ro_dlv0", dp(0), 32'h0040_0100);
    check_eq("ro_dlv1", dp(1), 32'h0040_0104);
    check_eq("ro_data0", dd(0), mem_word(32'h0040_0100));

    // Redirect in the same cycle as a response and a head pop
    lat = 2;
    bus.inst_ready = 1'b0;
    do_reset(2);
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
        if (bus.imem_rsp_valid && bus.inst_valid) found = 1'b1;
        else tick();
      end
      check_eq("co_setup", 32'(found), 32'd1);
    end
    bus.inst_ready = 1'b1;
    clear_logs();
    do_redirect(32'h0040_0300);
    check_eq("co_pop_count", 32'(dlv_pc.size()), 32'd1);
    check_eq("co_pop_pc", dp(0), RST_PC);
    check_eq("co_inst_valid", 32'(bus.inst_valid), 32'd0);
    wait_dlv(2, 30, "co_after");
    check_eq("co_next_pc", dp(1), 32'h0040_0300);

    // Address wrap at the top of the 32-bit space
    lat = 1;
    bus.inst_ready = 1'b1;
    do_reset(2);
    do_redirect(32'hFFFF_FFFC);
    clear_logs();
    wait_acc(20, "wr_acc");
    check_eq("wr_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    check_eq("wr_pc_next", pc_next, 32'h0000_0000);
    wait_dlv(2, 30, "wr_seq");
    check_eq("wr_dlv0", dp(0), 32'hFFFF_FFFC);
    check_eq("wr_dlv1", dp(1), 32'h0000_0000);
    check_eq("wr_data1", dd(1), mem_word(32'h0000_0000));

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect target blocks fetching until a new redirect
    lat = 1;
    do_reset(2);
    check_eq("al_rst_flag", 32'(fetch_misaligned), 32'd0);
    do_redirect(32'h0040_0102);
    clear_logs();
    repeat (5) tick();
    check_eq("al_flag_set", 32'(fetch_misaligned), 32'd1);
    check_eq("al_no_req", 32'(req_log.size()), 32'd0);
    check_eq("al_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("al_pc_hold", pc_next, 32'h0040_0102);
    do_redirect(32'h0040_0200);
    check_eq("al_flag_clr", 32'(fetch_misaligned), 32'd0);
    clear_logs();
    wait_dlv(1, 30, "al_resume");
    check_eq("al_req0", rq(0), 32'h0040_0200);
    check_eq("al_dlv0", dp(0), 32'h0040_0200);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
